rf_dsp_bringup_seq: RTL
=======================

// Module: rf_dsp_bringup_seq
//
// PURPOSE
//   Sequences reset release and data enable for the 200 MHz RF DSP chain
//   (400 MHz core, 2-to-4 up-converter, 4-to-2 down-converter) in the data_clk domain.
//   Order: FIR reset, DAC path reset, ADC path reset, ADC data enable, then ADC output valid check.
//   Reports ready/timeout status to the RFDC register block.
//   Outputs are levels; existing synchronizers carry them into the rclk/rclk2x domains.
//
// PARAMETERS
//   SETTLE_CYCLES   16    cycles held in HOLD, DAC and ADC states (>=1)
//   FLUSH_CYCLES    64    cycles from FIR reset release to DAC reset release (>=1)
//   TIMEOUT_CYCLES  4096  max cycles in WAIT_VALID before ERROR (>=1)
//   NUM_CHANNELS    2     ADC channels checked for valid
//
// PORTS
//   data_clk          in   1    sole clock
//   resetn_dclk       in   1    synchronous, active-low reset
//   enable_req        in   1    level; 1 = bring chain up, 0 = hold chain in reset
//   restart           in   1    1-cycle pulse; re-run the sequence from HOLD
//   chan_mask         in   NUM_CHANNELS  1 = channel included in valid check
//   adc_tvalid        in   NUM_CHANNELS  adc_data_out_tvalid_* of the down-converter
//   fir_resetn        out  1    to fir_resetn_rclk2x synchronizer
//   dac_resetn        out  1    to dac_data_in_resetn_* synchronizers
//   adc_resetn        out  1    to adc_data_out_resetn_dclk
//   adc_enable        out  1    to adc_enable_data_rclk synchronizer
//   ready             out  1    chain running, all masked channels valid
//   timeout_err       out  1    sticky; WAIT_VALID expired
//   seq_state         out  3    current state encoding, for status readback
//
// BEHAVIOUR
//   - All outputs registered. Reset value of every output is 0; state resets to IDLE.
//   - Counter: one down-counter of width $clog2(max param + 1).
//     It loads N-1 on entry to a timed state. The exit condition is counter==0.
//   - State encoding: IDLE=0, HOLD=1, FIR=2, DAC=3, ADC=4, WAIT_VALID=5, RUN=6, ERROR=7.
//   - IDLE: all outputs 0. enable_req=1 -> HOLD.
//   - HOLD: clears timeout_err. After SETTLE_CYCLES -> FIR, with fir_resetn=1.
//   - FIR: after FLUSH_CYCLES -> DAC, with dac_resetn=1.
//   - DAC: after SETTLE_CYCLES -> ADC, with adc_resetn=1.
//   - ADC: after SETTLE_CYCLES -> WAIT_VALID, with adc_enable=1.
//   - WAIT_VALID: if (adc_tvalid & chan_mask) == chan_mask -> RUN, with ready=1.
//     Else, when the counter hits 0 -> ERROR.
//   - RUN: holds all enables. A masked-channel valid drop does NOT leave RUN.
//   - ERROR: fir/dac/adc resetn and adc_enable forced 0; timeout_err=1; ready=0.
//   - Priority in every state: enable_req=0 -> IDLE, then restart -> HOLD, then normal transitions.
//   - Output timing: outputs track the next state, so they change on the same edge as seq_state.
//     Each resetn is 1 iff the state is at or past its release state and not ERROR.
//   - restart in HOLD reloads the counter (sequence restarts).
//   - restart in IDLE is ignored.
//   - chan_mask=0 makes WAIT_VALID exit to RUN after 1 cycle.
//   - Mid-operation deassertion of resetn_dclk: all outputs 0 next edge, state IDLE.
//   - Default timeline from enable_req sampled at edge 0:
//     HOLD@1, FIR@17, DAC@81, ADC@97, WAIT_VALID@113.
//
// STRUCTURE
//   - Shared include rf_seq_regs.vh holds state-encoding localparams.
//     Status-register bit offsets (ready, timeout_err, seq_state) go in the same file.
//   - No sub-module; the counter and FSM stay inline in a single always block
//     plus an output decode.
//
// TESTING
//   - Defaults; enable_req=1 at cycle 0; adc_tvalid=2'b11 from cycle 120.
//     -> fir_resetn rises @17, dac_resetn @81, adc_resetn @97, adc_enable @113, ready @121.
//   - adc_tvalid held 0; chan_mask=2'b11.
//     -> ERROR at 113+4096; timeout_err=1; all resetn=0; stays until restart.
//   - In RUN, enable_req=0 for 1 cycle.
//     -> next edge IDLE, all outputs 0.
//     enable_req=1 again -> full sequence replays with identical timing.
//   - restart pulse at cycle 90 (DAC state).
//     -> HOLD@91, dac_resetn and fir_resetn drop @91, fir_resetn rises again @107.
//   - chan_mask=2'b01, adc_tvalid=2'b01 -> RUN; chan_mask=2'b00 -> RUN one cycle after WAIT_VALID.
//   - resetn_dclk pulsed low during FIR state -> IDLE, outputs 0, timeout_err cleared.

Source files
------------

// File: rtl/rf_dsp_bringup_seq_pkg.sv
// Shared types and constants for the RF DSP chain bring-up sequencer:
// state encoding, status-register bit offsets and a sizing helper.
package rf_dsp_bringup_seq_pkg;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StHold      = 3'd1,
        StFir       = 3'd2,
        StDac       = 3'd3,
        StAdc       = 3'd4,
        StWaitValid = 3'd5,
        StRun       = 3'd6,
        StError     = 3'd7
    } seq_state_e;

    // Bit positions of the sequencer fields in the RFDC status register.
    localparam int unsigned StatusReadyBit   = 0;
    localparam int unsigned StatusTimeoutBit = 1;
    localparam int unsigned StatusStateLsb   = 4;
    localparam int unsigned StatusStateWidth = 3;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rf_dsp_bringup_seq_if.sv
// Control, ADC-valid and status signals between the bring-up sequencer and its
// surroundings; the sequencer takes the slave side.
interface rf_dsp_bringup_seq_if #(
    parameter int unsigned NUM_CHANNELS = 2
);

    logic                    enable_req;
    logic                    restart;
    logic [NUM_CHANNELS-1:0] chan_mask;
    logic [NUM_CHANNELS-1:0] adc_tvalid;

    logic                    fir_resetn;
    logic                    dac_resetn;
    logic                    adc_resetn;
    logic                    adc_enable;
    logic                    ready;
    logic                    timeout_err;
    logic [2:0]              seq_state;

    modport master (
        output enable_req, restart, chan_mask, adc_tvalid,
        input  fir_resetn, dac_resetn, adc_resetn, adc_enable, ready, timeout_err, seq_state
    );

    modport slave (
        input  enable_req, restart, chan_mask, adc_tvalid,
        output fir_resetn, dac_resetn, adc_resetn, adc_enable, ready, timeout_err, seq_state
    );

endinterface

// File: rtl/rf_dsp_bringup_seq.sv
// Reset-release / data-enable sequencer for the RF DSP chain in the data_clk domain.
// FIR, DAC path, ADC path, ADC enable, then waits for all masked ADC channels valid.
module rf_dsp_bringup_seq
    import rf_dsp_bringup_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned FLUSH_CYCLES   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned NUM_CHANNELS   = 2
) (
    input logic                 data_clk,
    input logic                 resetn_dclk,
    rf_dsp_bringup_seq_if.slave bus
);

    localparam int unsigned MaxCycles = max3(SETTLE_CYCLES, FLUSH_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] FlushLoad   = CntW'(FLUSH_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYCLES - 1);

    seq_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic fir_resetn_q, fir_resetn_d;
    logic dac_resetn_q, dac_resetn_d;
    logic adc_resetn_q, adc_resetn_d;
    logic adc_enable_q, adc_enable_d;
    logic ready_q, ready_d;
    logic timeout_err_q, timeout_err_d;

    logic [NUM_CHANNELS-1:0] valid_masked;
    logic                    all_valid;
    logic                    cnt_zero;
    logic [CntW-1:0]         cnt_dec;

    assign valid_masked = bus.adc_tvalid & bus.chan_mask;
    assign all_valid    = (valid_masked == bus.chan_mask);
    assign cnt_zero     = (cnt_q == '0);
    assign cnt_dec      = cnt_q - CntW'(1);

    always_ff @(posedge data_clk) begin
        if (!resetn_dclk) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            fir_resetn_q  <= 1'b0;
            dac_resetn_q  <= 1'b0;
            adc_resetn_q  <= 1'b0;
            adc_enable_q  <= 1'b0;
            ready_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fir_resetn_q  <= fir_resetn_d;
            dac_resetn_q  <= dac_resetn_d;
            adc_resetn_q  <= adc_resetn_d;
            adc_enable_q  <= adc_enable_d;
            ready_q       <= ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // enable_req dominates, then restart, then the per-state progression.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.enable_req) begin
            state_d = StIdle;
        end else if (bus.restart && (state_q != StIdle)) begin
            state_d = StHold;
            cnt_d   = SettleLoad;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StHold;
                    cnt_d   = SettleLoad;
                end
                StHold: begin
                    if (cnt_zero) begin
                        state_d = StFir;
                        cnt_d   = FlushLoad;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                StFir: begin
                    if (cnt_zero) begin
                        state_d = StDac;
                        cnt_d   = SettleLoad;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                StDac: begin
                    if (cnt_zero) begin
                        state_d = StAdc;
                        cnt_d   = SettleLoad;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                StAdc: begin
                    if (cnt_zero) begin
                        state_d = StWaitValid;
                        cnt_d   = TimeoutLoad;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                StWaitValid: begin
                    if (all_valid) begin
                        state_d = StRun;
                    end else if (cnt_zero) begin
                        state_d = StError;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                StRun, StError: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as seq_state.
    always_comb begin
        fir_resetn_d  = 1'b0;
        dac_resetn_d  = 1'b0;
        adc_resetn_d  = 1'b0;
        adc_enable_d  = 1'b0;
        ready_d       = 1'b0;
        timeout_err_d = 1'b0;
        unique case (state_d)
            StIdle, StHold: begin
                fir_resetn_d = 1'b0;
            end
            StFir: begin
                fir_resetn_d = 1'b1;
            end
            StDac: begin
                fir_resetn_d = 1'b1;
                dac_resetn_d = 1'b1;
            end
            StAdc: begin
                fir_resetn_d = 1'b1;
                dac_resetn_d = 1'b1;
                adc_resetn_d = 1'b1;
            end
            StWaitValid: begin
                fir_resetn_d = 1'b1;
                dac_resetn_d = 1'b1;
                adc_resetn_d = 1'b1;
                adc_enable_d = 1'b1;
            end
            StRun: begin
                fir_resetn_d = 1'b1;
                dac_resetn_d = 1'b1;
                adc_resetn_d = 1'b1;
                adc_enable_d = 1'b1;
                ready_d      = 1'b1;
            end
            StError: begin
                timeout_err_d = 1'b1;
            end
        endcase
    end

    assign bus.fir_resetn  = fir_resetn_q;
    assign bus.dac_resetn  = dac_resetn_q;
    assign bus.adc_resetn  = adc_resetn_q;
    assign bus.adc_enable  = adc_enable_q;
    assign bus.ready       = ready_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.seq_state   = state_q;

endmodule
